// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix multiplier.
//   state_t         : controller states
//   default_aw()    : full-precision accumulator width for an N x N product of DW-bit operands
//   compute_cycles(): cycles needed to flush skewed operands through an N x N array (3N-2)
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPUTE = 2'd2,
      OUTPUT  = 2'd3
   } state_t;

   function automatic int default_aw(input int n, input int dw);
      return 2 * dw + $clog2(n);
   endfunction

   function automatic int compute_cycles(input int n);
      return 3 * n - 2;
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary MAC processing element.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : zero the accumulator and the forwarded operands
//   en         : accumulate a_in*b_in and forward the operands
//   a_in/b_in  : operands arriving from the left / top neighbour
//   a_out/b_out: registered operands toward the right / lower neighbour
//   acc        : registered accumulator
// Build option: SYSTOLIC_MATMUL_SIGNED_EN selects two's-complement operands
// with sign extension; otherwise operands are unsigned and zero-extended.
module systolic_pe #(
   parameter int DW = 8,
   parameter int AW = 18
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] a_in,
   input  logic [DW-1:0] b_in,
   output logic [DW-1:0] a_out,
   output logic [DW-1:0] b_out,
   output logic [AW-1:0] acc
);

   localparam int PW = 2 * DW;

   logic [PW-1:0] a_ext;
   logic [PW-1:0] b_ext;
   logic [PW-1:0] prod;
   logic [AW-1:0] prod_ext;

   // Operands are widened to the product width first so the truncated
   // product holds the exact 2*DW-bit result in either number format.
`ifdef SYSTOLIC_MATMUL_SIGNED_EN
   assign a_ext    = {{DW{a_in[DW-1]}}, a_in};
   assign b_ext    = {{DW{b_in[DW-1]}}, b_in};
   assign prod     = a_ext * b_ext;
   assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
`else
   assign a_ext    = {{DW{1'b0}}, a_in};
   assign b_ext    = {{DW{1'b0}}, b_in};
   assign prod     = a_ext * b_ext;
   assign prod_ext = {{(AW-PW){1'b0}}, prod};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc   <= '0;
         a_out <= '0;
         b_out <= '0;
      end else if (clr) begin
         acc   <= '0;
         a_out <= '0;
         b_out <= '0;
      end else if (en) begin
         acc   <= acc + prod_ext;
         a_out <= a_in;
         b_out <= b_in;
      end
   end

endmodule

// File: rtl/systolic_matmul.sv
// N x N output-stationary systolic matrix multiplier, C = A x B.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid / in_ready : operand beat handshake; beat k carries column k of A
//                         (a_col, A[i][k] at [i*DW +: DW]) and row k of B
//                         (b_row, B[k][j] at [j*DW +: DW])
//   out_valid/out_ready : result handshake; one row of C per beat on res_row
//                         (C[r][j] at [j*AW +: AW]) with its index on res_idx
//   busy                : high whenever the controller is not idle
// Build option: SYSTOLIC_MATMUL_SIGNED_EN (signed arithmetic, see systolic_pe).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for beat 0; accepting it clears the accumulators
// LOAD    | collecting beats 1..N-1 into the operand buffers
// COMPUTE | t = 0..3N-3, skewed operands driven into the PE array
// OUTPUT  | first cycle registers row 0, then one row per out transfer
module systolic_matmul
   import systolic_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int AW = default_aw(N, DW),
   parameter int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] a_col,
   input  logic [N*DW-1:0] b_row,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N*AW-1:0] res_row,
   output logic [IW-1:0]   res_idx,
   output logic            busy
);

   localparam int CC = compute_cycles(N);
   localparam int TW = $clog2(CC);

   state_t        state;
   state_t        state_next;

   logic [DW-1:0] a_buf [N][N];   // a_buf[i][k] = A[i][k]
   logic [DW-1:0] b_buf [N][N];   // b_buf[k][j] = B[k][j]
   logic [IW-1:0] k_cnt;
   logic [TW-1:0] t_cnt;
   logic          in_ready_q;
   logic          out_valid_q;

   logic          accept;
   logic          out_xfer;
   logic          last_beat;
   logic          last_t;
   logic          last_row;
   logic          pe_clr;
   logic          pe_en;
   logic [IW-1:0] row_sel;

   logic [DW-1:0] a_edge [N];
   logic [DW-1:0] b_edge [N];
   logic [DW-1:0] a_h    [N][N+1];
   logic [DW-1:0] b_v    [N+1][N];
   logic [AW-1:0] acc_w  [N][N];

   assign accept    = in_valid && in_ready_q;
   assign out_xfer  = out_valid_q && out_ready;
   assign last_beat = (k_cnt == IW'(N-1));
   assign last_t    = (t_cnt == TW'(CC-1));
   assign last_row  = (res_idx == IW'(N-1));
   assign pe_clr    = accept && (state == IDLE);
   assign pe_en     = (state == COMPUTE);

   // Row to register next: row 0 on the loading cycle, else the following row.
   assign row_sel   = out_valid_q ? res_idx + IW'(1) : '0;

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)                state_next = LOAD;
         LOAD:    if (accept && last_beat)   state_next = COMPUTE;
         COMPUTE: if (last_t)                state_next = OUTPUT;
         OUTPUT:  if (out_xfer && last_row)  state_next = IDLE;
         default:                            state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
               a_buf[i][k] <= '0;
               b_buf[i][k] <= '0;
            end
         end
         k_cnt       <= '0;
         t_cnt       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         res_row     <= '0;
         res_idx     <= '0;
      end else begin
         // k_cnt is zero in IDLE, so beat 0 lands in slot 0.
         if (accept) begin
            for (int i = 0; i < N; i++) begin
               a_buf[i][k_cnt] <= a_col[i*DW +: DW];
               b_buf[k_cnt][i] <= b_row[i*DW +: DW];
            end
            if ((state == LOAD) && last_beat) begin
               k_cnt      <= '0;
               in_ready_q <= 1'b0;
            end else begin
               k_cnt <= k_cnt + IW'(1);
            end
         end

         if (state == COMPUTE) begin
            t_cnt <= last_t ? '0 : t_cnt + TW'(1);
         end

         if (state == OUTPUT) begin
            if (!out_valid_q || (out_ready && !last_row)) begin
               out_valid_q <= 1'b1;
               res_idx     <= row_sel;
               for (int j = 0; j < N; j++) begin
                  res_row[j*AW +: AW] <= acc_w[row_sel][j];
               end
            end else if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               res_idx     <= '0;
               res_row     <= '0;
            end
         end
      end
   end

   // Skewed injection: row i / column i sees element t-i of its stream,
   // zero outside the matrix bounds.
   always_comb begin
      int d;
      d = 0;
      for (int i = 0; i < N; i++) begin
         a_edge[i] = '0;
         b_edge[i] = '0;
      end
      if (state == COMPUTE) begin
         for (int i = 0; i < N; i++) begin
            d = int'(t_cnt) - i;
            if ((d >= 0) && (d < N)) begin
               a_edge[i] = a_buf[i][d[IW-1:0]];
               b_edge[i] = b_buf[d[IW-1:0]][i];
            end
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      assign a_h[i][0] = a_edge[i];
      assign b_v[0][i] = b_edge[i];
      for (genvar j = 0; j < N; j++) begin : g_col
         systolic_pe #(
            .DW (DW),
            .AW (AW)
         ) u_pe (
            .clk   (clk),
            .reset (reset),
            .clr   (pe_clr),
            .en    (pe_en),
            .a_in  (a_h[i][j]),
            .b_in  (b_v[i][j]),
            .a_out (a_h[i][j+1]),
            .b_out (b_v[i+1][j]),
            .acc   (acc_w[i][j])
         );
      end
   end

endmodule

// File: tb/tb_systolic_matmul.sv
module tb_systolic_matmul;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int AW = 2*DW + $clog2(N);
   localparam int IW = $clog2(N);

   typedef struct {
      logic [N*AW-1:0] row;
      logic [IW-1:0]   idx;
   } res_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] a_col;
   logic [N*DW-1:0] b_row;
   logic            out_valid;
   logic            out_ready;
   logic [N*AW-1:0] res_row;
   logic [IW-1:0]   res_idx;
   logic            busy;

   int   checks = 0;
   int   errors = 0;
   int   ma [N][N];
   int   mb [N][N];
   res_t exp_q[$];
   res_t obs_q[$];
   res_t stall_q[$];

   systolic_matmul #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_col     (a_col),
      .b_row     (b_row),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res_row   (res_row),
      .res_idx   (res_idx),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic int ev(input int x);
`ifdef SYSTOLIC_MATMUL_SIGNED_EN
      return (x >= (1 << (DW-1))) ? x - (1 << DW) : x;
`else
      return x;
`endif
   endfunction

   function automatic logic [N*AW-1:0] model_row(input int r);
      logic [N*AW-1:0] v;
      int c;
      v = '0;
      for (int j = 0; j < N; j++) begin
         c = 0;
         for (int k = 0; k < N; k++) c += ev(ma[r][k]) * ev(mb[k][j]);
         v[j*AW +: AW] = c[AW-1:0];
      end
      return v;
   endfunction

   task automatic fill(input int a_kind, input int b_kind, input int av, input int bv);
      // kind 0: constant, 1: identity, 2: 4k+j+1, 3: random
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            case (a_kind)
               0: ma[i][j] = av;
               1: ma[i][j] = (i == j) ? 1 : 0;
               2: ma[i][j] = 4*i + j + 1;
               default: ma[i][j] = int'($urandom_range(0, 255));
            endcase
            case (b_kind)
               0: mb[i][j] = bv;
               1: mb[i][j] = (i == j) ? 1 : 0;
               2: mb[i][j] = 4*i + j + 1;
               default: mb[i][j] = int'($urandom_range(0, 255));
            endcase
         end
      end
   endtask

   task automatic send_matrix(input bit push, input int gap_after, input int gap_len);
      int cnt;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            a_col[i*DW +: DW] = DW'(ma[i][k]);
            b_row[i*DW +: DW] = DW'(mb[k][i]);
         end
         in_valid = 1'b1;
         cnt = 0;
         @(negedge clk);
         while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
         end
         if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles at beat %0d, required 1", in_ready, cnt, k);
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         if (k == gap_after) begin
            repeat (gap_len) @(posedge clk);
            #1;
         end
      end
      if (push) begin
         for (int r = 0; r < N; r++) begin
            res_t e;
            e.row = model_row(r);
            e.idx = IW'(r);
            exp_q.push_back(e);
         end
      end
   endtask

   // Collects rows without judging them; called at #1 after the last beat edge.
   task automatic drain(input int stall_row, input int stall_len, output int lat);
      int cyc;
      int stalled;
      res_t o;
      cyc = 0;
      stalled = 0;
      out_ready = 1'b1;
      while (!out_valid && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      lat = cyc;
      for (int c = 0; c < N + stall_len + 4; c++) begin
         if (out_valid && int'(res_idx) == stall_row && stalled < stall_len) begin
            out_ready = 1'b0;
            stalled++;
         end else begin
            out_ready = 1'b1;
         end
         @(negedge clk);
         o.row = res_row;
         o.idx = res_idx;
         if (out_valid && out_ready) obs_q.push_back(o);
         else if (out_valid) stall_q.push_back(o);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: in_ready=%0b out_valid=%0b busy=%0b, required 1 0 0", in_ready, out_valid, busy);
      end
      checks++;
      if (res_row !== '0 || res_idx !== '0) begin
         errors++;
         $display("FAIL reset_data: res_row=%h res_idx=%0d, required 0 0", res_row, res_idx);
      end
   endtask

   task automatic test_identity;
      int lat;
      fill(1, 2, 0, 0);
      send_matrix(1'b1, -1, 0);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL ident_busy: busy=%0b in_ready=%0b, required 1 0", busy, in_ready);
      end
      drain(-1, 0, lat);
      checks++;
      if (lat !== 3*N-1) begin
         errors++;
         $display("FAIL ident_latency: got %0d cycles, required %0d", lat, 3*N-1);
      end
      checks++;
      if (obs_q.size() !== N) begin
         errors++;
         $display("FAIL ident_rows: got %0d transfers, required %0d", obs_q.size(), N);
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         res_t o, e;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.row !== e.row || o.idx !== e.idx) begin
            errors++;
            $display("FAIL ident_row: got idx %0d row %h, required idx %0d row %h", o.idx, o.row, e.idx, e.row);
         end
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ident_done: out_valid=%0b in_ready=%0b busy=%0b, required 0 1 0", out_valid, in_ready, busy);
      end
      exp_q.delete(); obs_q.delete(); stall_q.delete();
   endtask

   task automatic test_full_scale;
      int lat;
      fill(0, 0, 255, 255);
      send_matrix(1'b1, -1, 0);
      drain(-1, 0, lat);
      checks++;
      if (obs_q.size() !== N) begin
         errors++;
         $display("FAIL full_rows: got %0d transfers, required %0d", obs_q.size(), N);
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         res_t o, e;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.row !== e.row || o.idx !== e.idx) begin
            errors++;
            $display("FAIL full_row: got idx %0d row %h, required idx %0d row %h", o.idx, o.row, e.idx, e.row);
         end
      end
      exp_q.delete(); obs_q.delete(); stall_q.delete();
   endtask

   task automatic test_stall;
      int lat;
      res_t row1;
      fill(0, 0, 255, 255);
      send_matrix(1'b1, -1, 0);
      row1 = exp_q[1];
      // Junk offered while the array computes must be refused.
      a_col = '1;
      b_row = '1;
      in_valid = 1'b1;
      repeat (6) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready: in_ready=%0b during compute, required 0", in_ready);
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain(1, 5, lat);
      checks++;
      if (stall_q.size() !== 5) begin
         errors++;
         $display("FAIL stall_len: got %0d stalled cycles, required 5", stall_q.size());
      end
      while (stall_q.size() > 0) begin
         res_t s;
         s = stall_q.pop_front();
         checks++;
         if (s.row !== row1.row || s.idx !== row1.idx) begin
            errors++;
            $display("FAIL stall_hold: got idx %0d row %h, required idx %0d row %h", s.idx, s.row, row1.idx, row1.row);
         end
      end
      checks++;
      if (obs_q.size() !== N) begin
         errors++;
         $display("FAIL stall_rows: got %0d transfers, required %0d", obs_q.size(), N);
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         res_t o, e;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.row !== e.row || o.idx !== e.idx) begin
            errors++;
            $display("FAIL stall_row: got idx %0d row %h, required idx %0d row %h", o.idx, o.row, e.idx, e.row);
         end
      end
      exp_q.delete(); obs_q.delete(); stall_q.delete();
   endtask

   task automatic test_gap;
      int lat;
      fill(1, 2, 0, 0);
      send_matrix(1'b1, 1, 3);
      drain(-1, 0, lat);
      checks++;
      if (lat !== 3*N-1) begin
         errors++;
         $display("FAIL gap_latency: got %0d cycles, required %0d", lat, 3*N-1);
      end
      checks++;
      if (obs_q.size() !== N) begin
         errors++;
         $display("FAIL gap_rows: got %0d transfers, required %0d", obs_q.size(), N);
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         res_t o, e;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.row !== e.row || o.idx !== e.idx) begin
            errors++;
            $display("FAIL gap_row: got idx %0d row %h, required idx %0d row %h", o.idx, o.row, e.idx, e.row);
         end
      end
      exp_q.delete(); obs_q.delete(); stall_q.delete();
   endtask

   task automatic test_reset_abort;
      int lat;
      fill(0, 0, 255, 255);
      send_matrix(1'b0, -1, 0);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || res_row !== '0 || res_idx !== '0) begin
         errors++;
         $display("FAIL abort_during: in_ready=%0b out_valid=%0b busy=%0b res_row=%h res_idx=%0d, required 1 0 0 0 0",
                  in_ready, out_valid, busy, res_row, res_idx);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || res_row !== '0 || res_idx !== '0) begin
         errors++;
         $display("FAIL abort_after: in_ready=%0b out_valid=%0b busy=%0b res_row=%h res_idx=%0d, required 1 0 0 0 0",
                  in_ready, out_valid, busy, res_row, res_idx);
      end
      fill(1, 1, 0, 0);
      send_matrix(1'b1, -1, 0);
      drain(-1, 0, lat);
      checks++;
      if (obs_q.size() !== N) begin
         errors++;
         $display("FAIL abort_rows: got %0d transfers, required %0d", obs_q.size(), N);
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         res_t o, e;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.row !== e.row || o.idx !== e.idx) begin
            errors++;
            $display("FAIL abort_row: got idx %0d row %h, required idx %0d row %h", o.idx, o.row, e.idx, e.row);
         end
      end
      exp_q.delete(); obs_q.delete(); stall_q.delete();
   endtask

   task automatic test_data_runs;
      int lat;
      for (int run = 0; run < 3; run++) begin
`ifdef SYSTOLIC_MATMUL_SIGNED_EN
         case (run)
            0:       fill(0, 0, 128, 128);   // -128 everywhere
            1:       fill(0, 0, 255, 1);     // A = -1, B = 1
            default: fill(3, 3, 0, 0);
         endcase
`else
         case (run)
            0:       fill(2, 1, 0, 0);
            1:       fill(3, 2, 0, 0);
            default: fill(3, 3, 0, 0);
         endcase
`endif
         send_matrix(1'b1, -1, 0);
         drain(-1, 0, lat);
         checks++;
         if (obs_q.size() !== N) begin
            errors++;
            $display("FAIL data_rows: run %0d got %0d transfers, required %0d", run, obs_q.size(), N);
         end
         while (obs_q.size() > 0 && exp_q.size() > 0) begin
            res_t o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.row !== e.row || o.idx !== e.idx) begin
               errors++;
               $display("FAIL data_row: run %0d got idx %0d row %h, required idx %0d row %h", run, o.idx, o.row, e.idx, e.row);
            end
         end
         exp_q.delete(); obs_q.delete(); stall_q.delete();
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_col     = '0;
      b_row     = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      reset = 1'b0;
      @(posedge clk);
      #1;
      test_reset;
      test_identity;
      test_full_scale;
      test_stall;
      test_gap;
      test_reset_abort;
      test_data_runs;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
